// File: rtl/lm80c_sio_tx.sv
// lm80c_sio_tx: Z80 I/O-mapped serial transmitter.
// The CPU pushes bytes through the bus responder into a small TX FIFO.
// A frame FSM serialises them on txd: start bit, 8 data bits LSB first,
// optional parity, then one or two stop bits. A level interrupt requests
// more data when the transmitter is idle and the FIFO is empty.
module lm80c_sio_tx #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd383
) (
    input  logic       sys_clock,
    input  logic       reset_n,
    input  logic       ce_n,
    input  logic [1:0] cs,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic       m1_n,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       txd,
    output logic       int_n
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP1  = 3'd4;
    localparam logic [2:0] ST_STOP2  = 3'd5;

    // Bus strobes; an INTACK cycle (m1_n low) never qualifies as an access.
    logic wr_s, rd_s, wr_rise, rd_rise, rd_fall;
    logic wr_s_q, rd_s_q;
    logic [1:0] rd_cs_q, rd_cs_d;

    // Configuration and status
    logic [4:0]  ctrl_q, ctrl_d;       // b0 tx_en, b1 int_en, b2 two_stop, b3 par_en, b4 par_odd
    logic [15:0] div_q, div_d;
    logic        ovr_q, ovr_d;
    logic [7:0]  dout_q, dout_d;
    logic [7:0]  status;

    // FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          fifo_empty, fifo_full, push_req, push_ok, pop;

    // Frame engine; the per-frame copies isolate a running frame from config writes.
    logic [2:0]  state_q, state_d;
    logic [15:0] baud_q, baud_d, fdiv_q, fdiv_d;
    logic [7:0]  fdata_q, fdata_d;
    logic        fpar_en_q, fpar_en_d, fpar_odd_q, fpar_odd_d, ftwo_q, ftwo_d;
    logic [2:0]  bit_q, bit_d;
    logic        txd_q, txd_d, int_n_q, int_n_d;
    logic        tick, can_load, frame_end;

    assign wr_s    = ~ce_n & ~iorq_n & ~wr_n & m1_n;
    assign rd_s    = ~ce_n & ~iorq_n & ~rd_n & m1_n;
    assign wr_rise = wr_s & ~wr_s_q;
    assign rd_rise = rd_s & ~rd_s_q;
    assign rd_fall = ~rd_s & rd_s_q;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_CNT);
    assign status     = {3'b000, ~int_n_q, ovr_q, (state_q != ST_IDLE), fifo_full, fifo_empty};

    assign dout  = dout_q;
    assign txd   = txd_q;
    assign int_n = int_n_q;

    // Next-state logic: frame engine, FIFO bookkeeping, register file, read mux, interrupt.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        fdiv_d     = fdiv_q;
        fdata_d    = fdata_q;
        fpar_en_d  = fpar_en_q;
        fpar_odd_d = fpar_odd_q;
        ftwo_d     = ftwo_q;
        bit_d      = bit_q;
        txd_d      = txd_q;
        pop        = 1'b0;
        frame_end  = 1'b0;
        tick       = (baud_q == fdiv_q);
        can_load   = ctrl_q[0] & ~fifo_empty;

        if (state_q != ST_IDLE) begin
            baud_d = tick ? 16'd0 : baud_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: ;
            ST_START: if (tick) begin
                state_d = ST_DATA;
                bit_d   = 3'd0;
                txd_d   = fdata_q[0];
            end
            ST_DATA: if (tick) begin
                if (bit_q == 3'd7) begin
                    if (fpar_en_q) begin
                        state_d = ST_PARITY;
                        txd_d   = (^fdata_q) ^ fpar_odd_q;
                    end else begin
                        state_d = ST_STOP1;
                        txd_d   = 1'b1;
                    end
                end else begin
                    bit_d = bit_q + 3'd1;
                    txd_d = fdata_q[bit_q + 3'd1];
                end
            end
            ST_PARITY: if (tick) begin
                state_d = ST_STOP1;
                txd_d   = 1'b1;
            end
            ST_STOP1: if (tick) begin
                if (ftwo_q) begin
                    state_d = ST_STOP2;
                    txd_d   = 1'b1;
                end else begin
                    frame_end = 1'b1;
                end
            end
            ST_STOP2: if (tick) frame_end = 1'b1;
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Frame load from idle or straight out of the last stop bit (no idle gap).
        if (((state_q == ST_IDLE) || frame_end) && can_load) begin
            pop        = 1'b1;
            fdata_d    = mem_q[rd_ptr_q];
            fdiv_d     = div_q;
            fpar_en_d  = ctrl_q[3];
            fpar_odd_d = ctrl_q[4];
            ftwo_d     = ctrl_q[2];
            baud_d     = 16'd0;
            txd_d      = 1'b0;
            state_d    = ST_START;
        end else if (frame_end) begin
            state_d = ST_IDLE;
            txd_d   = 1'b1;
        end

        // FIFO: a push while full is accepted only if a pop frees a slot this cycle.
        push_req = wr_rise & (cs == 2'd0);
        push_ok  = push_req & (~fifo_full | pop);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};

        // Register writes
        ctrl_d = ctrl_q;
        div_d  = div_q;
        if (wr_rise) begin
            case (cs)
                2'd1: ctrl_d      = din[4:0];
                2'd2: div_d[7:0]  = din;
                2'd3: div_d[15:8] = din;
                default: ;
            endcase
        end

        // Overrun: cleared when a status read ends, a new drop sets it again.
        ovr_d = ovr_q;
        if (rd_fall && (rd_cs_q == 2'd1)) ovr_d = 1'b0;
        if (push_req && !push_ok)         ovr_d = 1'b1;

        // Read data latched at the start of a read, held for its duration.
        rd_cs_d = rd_rise ? cs : rd_cs_q;
        dout_d  = 8'h00;
        if (rd_rise) begin
            case (cs)
                2'd0: dout_d = 8'h00;
                2'd1: dout_d = status;
                2'd2: dout_d = div_q[7:0];
                2'd3: dout_d = div_q[15:8];
                default: ;
            endcase
        end else if (rd_s) begin
            dout_d = dout_q;
        end

        int_n_d = ~(ctrl_d[1] & (cnt_d == '0) & (state_d == ST_IDLE));
    end

    // State registers with asynchronous reset.
    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_s_q     <= 1'b0;
            rd_s_q     <= 1'b0;
            rd_cs_q    <= 2'd0;
            ctrl_q     <= 5'd0;
            div_q      <= DEFAULT_DIV;
            ovr_q      <= 1'b0;
            dout_q     <= 8'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
            baud_q     <= 16'd0;
            fdiv_q     <= DEFAULT_DIV;
            fdata_q    <= 8'h00;
            fpar_en_q  <= 1'b0;
            fpar_odd_q <= 1'b0;
            ftwo_q     <= 1'b0;
            bit_q      <= 3'd0;
            txd_q      <= 1'b1;
            int_n_q    <= 1'b1;
        end else begin
            wr_s_q     <= wr_s;
            rd_s_q     <= rd_s;
            rd_cs_q    <= rd_cs_d;
            ctrl_q     <= ctrl_d;
            div_q      <= div_d;
            ovr_q      <= ovr_d;
            dout_q     <= dout_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            baud_q     <= baud_d;
            fdiv_q     <= fdiv_d;
            fdata_q    <= fdata_d;
            fpar_en_q  <= fpar_en_d;
            fpar_odd_q <= fpar_odd_d;
            ftwo_q     <= ftwo_d;
            bit_q      <= bit_d;
            txd_q      <= txd_d;
            int_n_q    <= int_n_d;
        end
    end

    // FIFO storage; the occupancy count alone defines emptiness, so no reset is needed.
    always_ff @(posedge sys_clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: tb/tb_lm80c_sio_tx.sv
// Bench for lm80c_sio_tx: directed bus transactions plus a serial-line
// receiver model that checks txd every cycle against queued bytes.
module tb_lm80c_sio_tx;
    logic       sys_clock = 1'b0;
    logic       reset_n   = 1'b0;
    logic       ce_n      = 1'b1;
    logic [1:0] cs        = 2'd0;
    logic       iorq_n    = 1'b1;
    logic       rd_n      = 1'b1;
    logic       wr_n      = 1'b1;
    logic       m1_n      = 1'b1;
    logic [7:0] din       = 8'h00;
    logic [7:0] dout;
    logic       txd;
    logic       int_n;

    lm80c_sio_tx #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd383)) dut (
        .sys_clock(sys_clock), .reset_n(reset_n), .ce_n(ce_n), .cs(cs),
        .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
        .din(din), .dout(dout), .txd(txd), .int_n(int_n)
    );

    always #5 sys_clock = ~sys_clock;

    int total = 0;
    int bad   = 0;

    // Model: bytes accepted but not yet seen on the line, plus current config.
    logic [7:0]  q[$];
    logic [4:0]  mctrl = 5'd0;
    logic [15:0] mdiv  = 16'd383;
    logic        mon_en = 1'b1;
    logic        mbusy  = 1'b0;
    logic [11:0] mbits;
    logic [7:0]  mbyte;
    int          mn, mper, mcyc;
    int          frames_seen = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Line-level frame as a sequence of bit values in transmission order.
    function automatic void frame_bits(input logic [7:0] b, input logic par_en, input logic par_odd,
                                       input logic two, output logic [11:0] bits, output int n);
        bits = '0;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin bits[n] = b[i]; n++; end
        if (par_en) begin bits[n] = (($countones(b) % 2) == 1) ^ par_odd; n++; end
        bits[n] = 1'b1; n++;
        if (two) begin bits[n] = 1'b1; n++; end
    endfunction

    // Receiver model: every cycle txd must be idle-high or the expected frame bit.
    always @(negedge sys_clock) begin
        if (mon_en) begin
            if (!mbusy) begin
                if (txd === 1'b0) begin
                    if (q.size() == 0) begin
                        chk("unexpected_start", {15'd0, txd}, 16'd1);
                    end else begin
                        mbyte = q.pop_front();
                        frame_bits(mbyte, mctrl[3], mctrl[4], mctrl[2], mbits, mn);
                        mper  = int'(mdiv) + 1;
                        mcyc  = 1;
                        mbusy = 1'b1;
                    end
                end else begin
                    chk("idle_line", {15'd0, txd}, 16'd1);
                end
            end else begin
                chk($sformatf("frame_%02h_bit%0d", mbyte, mcyc / mper), {15'd0, txd},
                    {15'd0, mbits[mcyc / mper]});
                mcyc++;
                if (mcyc == mn * mper) begin
                    mbusy = 1'b0;
                    frames_seen++;
                end
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(posedge sys_clock); #1;
        ce_n = 1'b0; iorq_n = 1'b0; wr_n = 1'b0; cs = a; din = d;
        case (a)
            2'd0: if (q.size() < 8) q.push_back(d);
            2'd1: mctrl = d[4:0];
            2'd2: mdiv[7:0] = d;
            2'd3: mdiv[15:8] = d;
            default: ;
        endcase
        @(posedge sys_clock); #1;
        ce_n = 1'b1; iorq_n = 1'b1; wr_n = 1'b1;
        $display("write cs=%0d data=%02h", a, d);
    endtask

    task automatic bus_read_chk(input logic [1:0] a, input logic [7:0] exp, input string name);
        @(posedge sys_clock); #1;
        ce_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0; cs = a;
        @(posedge sys_clock);
        @(negedge sys_clock); chk(name, {8'd0, dout}, {8'd0, exp});
        @(posedge sys_clock);
        @(negedge sys_clock); chk({name, "_hold"}, {8'd0, dout}, {8'd0, exp});
        @(posedge sys_clock); #1;
        ce_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1;
        @(posedge sys_clock);
        @(negedge sys_clock); chk({name, "_release"}, {8'd0, dout}, 16'd0);
        $display("read cs=%0d expect=%02h (%s)", a, exp, name);
    endtask

    task automatic wait_drain(input int bound, input string name);
        int c = 0;
        while ((q.size() != 0 || mbusy) && c < bound) begin
            @(negedge sys_clock);
            c++;
        end
        chk({name, "_drain"}, (c < bound) ? 16'd1 : 16'd0, 16'd1);
        @(negedge sys_clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] pb;
        int pn;

        // Model pin: hand-derived frames
        frame_bits(8'h55, 1'b0, 1'b0, 1'b0, pb, pn);
        chk("pin_8n1_bits", {4'd0, pb}, 16'b0000_0010_1010_1010);
        chk("pin_8n1_len", 16'(pn), 16'd10);
        frame_bits(8'h07, 1'b1, 1'b0, 1'b1, pb, pn);
        chk("pin_8e2_bits", {4'd0, pb}, 16'b0000_1110_0000_1110);
        chk("pin_8e2_len", 16'(pn), 16'd12);

        // Reset state
        repeat (3) @(negedge sys_clock);
        chk("rst_txd", {15'd0, txd}, 16'd1);
        chk("rst_int_n", {15'd0, int_n}, 16'd1);
        chk("rst_dout", {8'd0, dout}, 16'd0);
        @(posedge sys_clock); #1 reset_n = 1'b1;
        bus_read_chk(2'd1, 8'h01, "rst_status");
        bus_read_chk(2'd2, 8'h7F, "rst_div_lo");
        bus_read_chk(2'd3, 8'h01, "rst_div_hi");
        bus_read_chk(2'd0, 8'h00, "rst_data_reg");

        // 8N1 at divisor 3, with write-to-start latency
        bus_write(2'd2, 8'd3);
        bus_write(2'd3, 8'd0);
        bus_write(2'd1, 8'h01);
        bus_write(2'd0, 8'h55);
        @(negedge sys_clock); chk("lat_still_idle", {15'd0, txd}, 16'd1);
        @(negedge sys_clock); chk("lat_start_low", {15'd0, txd}, 16'd0);
        repeat (40) @(negedge sys_clock);
        chk("frames_8n1", 16'(frames_seen), 16'd1);
        bus_read_chk(2'd1, 8'h01, "status_after_8n1");

        // Even parity, two stop bits; status mid-frame shows busy
        bus_write(2'd1, 8'h0D);
        bus_write(2'd0, 8'h07);
        repeat (10) @(negedge sys_clock);
        bus_read_chk(2'd1, 8'h05, "status_busy");
        wait_drain(200, "parity");
        chk("frames_parity", 16'(frames_seen), 16'd2);
        bus_read_chk(2'd1, 8'h01, "status_after_parity");

        // Overflow with transmitter disabled, then drain in order
        bus_write(2'd1, 8'h00);
        for (int i = 0; i < 9; i++) bus_write(2'd0, 8'h10 + 8'(i));
        bus_read_chk(2'd1, 8'h0A, "status_full_ovr");
        bus_read_chk(2'd1, 8'h02, "status_ovr_cleared");
        bus_write(2'd1, 8'h01);
        wait_drain(800, "burst");
        chk("frames_burst", 16'(frames_seen), 16'd10);
        bus_read_chk(2'd1, 8'h01, "status_after_burst");

        // Long write strobe pushes exactly one byte
        bus_write(2'd1, 8'h00);
        @(posedge sys_clock); #1;
        ce_n = 1'b0; iorq_n = 1'b0; wr_n = 1'b0; cs = 2'd0; din = 8'hA5;
        q.push_back(8'hA5);
        repeat (20) @(posedge sys_clock);
        #1 ce_n = 1'b1; iorq_n = 1'b1; wr_n = 1'b1;
        $display("write cs=0 data=a5 held 20 cycles");
        bus_read_chk(2'd1, 8'h00, "status_one_entry");
        bus_write(2'd1, 8'h01);
        wait_drain(200, "long_write");
        repeat (20) @(negedge sys_clock);
        chk("frames_long_write", 16'(frames_seen), 16'd11);

        // Interrupt behaviour
        bus_write(2'd1, 8'h03);
        @(negedge sys_clock); chk("int_idle_empty", {15'd0, int_n}, 16'd0);
        bus_write(2'd0, 8'h3C);
        @(negedge sys_clock); chk("int_after_push", {15'd0, int_n}, 16'd1);
        wait_drain(200, "int_frame");
        @(negedge sys_clock); chk("int_after_frame", {15'd0, int_n}, 16'd0);
        bus_read_chk(2'd1, 8'h11, "status_int");
        bus_write(2'd1, 8'h01);
        @(negedge sys_clock); chk("int_en_cleared", {15'd0, int_n}, 16'd1);

        // Divisor change applies to the next frame
        bus_write(2'd2, 8'd5);
        bus_write(2'd0, 8'hC3);
        wait_drain(200, "div5");
        chk("frames_div5", 16'(frames_seen), 16'd13);
        bus_write(2'd2, 8'd3);

        // INTACK cycles are ignored
        @(posedge sys_clock); #1;
        ce_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b0; cs = 2'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clock); chk("intack_dout", {8'd0, dout}, 16'd0);
        end
        @(posedge sys_clock); #1;
        rd_n = 1'b1; wr_n = 1'b0; cs = 2'd0; din = 8'h99;
        repeat (3) @(posedge sys_clock);
        #1 ce_n = 1'b1; iorq_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
        $display("intack cycles issued");
        repeat (10) @(negedge sys_clock);
        bus_read_chk(2'd1, 8'h01, "status_after_intack");

        // Reset during data bit 3
        bus_write(2'd0, 8'h00);
        @(negedge sys_clock);
        @(negedge sys_clock); chk("rstmid_start", {15'd0, txd}, 16'd0);
        repeat (17) @(negedge sys_clock);
        chk("rstmid_bit3", {15'd0, txd}, 16'd0);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_txd", {15'd0, txd}, 16'd1);
        chk("rstmid_int_n", {15'd0, int_n}, 16'd1);
        q.delete();
        mbusy = 1'b0;
        mctrl = 5'd0;
        mdiv  = 16'd383;
        @(posedge sys_clock); #1 reset_n = 1'b1;
        mon_en = 1'b1;
        $display("reset pulsed mid-frame");
        bus_read_chk(2'd1, 8'h01, "rstmid_status");
        bus_read_chk(2'd2, 8'h7F, "rstmid_div_lo");
        bus_read_chk(2'd3, 8'h01, "rstmid_div_hi");
        repeat (10) @(negedge sys_clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
